// File: rtl/mem_access_if.sv
// mem_access_if: EX/MEM-side bus into the MEM stage plus its combinational/debug results
interface mem_access_if #(
  parameter int NB = 32,
  parameter int NB_SIZE_TYPE = 3,
  parameter int NB_ADDR = 8
);
  logic                    i_step;
  logic                    i_mem_read;
  logic                    i_mem_write;
  logic                    i_signed;
  logic [NB_SIZE_TYPE-1:0] i_word_size;
  logic [NB-1:0]           i_alu_result;
  logic [NB-1:0]           i_data_b_to_write;
  logic                    i_branch;
  logic                    i_cero;
  logic [NB_ADDR-1:0]      i_debug_addr;
  logic [NB-1:0]           o_read_data;
  logic                    o_pc_src;
  logic                    o_misaligned;
  logic                    o_ready;
  logic [NB-1:0]           o_debug_data;
  modport master (
    output i_step, i_mem_read, i_mem_write, i_signed, i_word_size, i_alu_result,
           i_data_b_to_write, i_branch, i_cero, i_debug_addr,
    input  o_read_data, o_pc_src, o_misaligned, o_ready, o_debug_data
  );
  modport slave (
    input  i_step, i_mem_read, i_mem_write, i_signed, i_word_size, i_alu_result,
           i_data_b_to_write, i_branch, i_cero, i_debug_addr,
    output o_read_data, o_pc_src, o_misaligned, o_ready, o_debug_data
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with cleared-on-reset data RAM, sized little-endian loads/stores and branch resolve
module mem_access_stage #(
  parameter int NB = 32,
  parameter int NB_SIZE_TYPE = 3,
  parameter int NB_ADDR = 8
) (
  input logic i_clk,
  input logic i_reset,
  mem_access_if.slave bus
);
  localparam int DEPTH = 2 ** NB_ADDR;
  localparam logic [NB_SIZE_TYPE-1:0] SZ_BYTE = '0;
  localparam logic [NB_SIZE_TYPE-1:0] SZ_HALF = NB_SIZE_TYPE'(1);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t             state, state_n;
  logic [NB-1:0]      mem [DEPTH];
  logic [NB_ADDR-1:0] ptr;
  logic [NB_ADDR-1:0] idx;
  logic [1:0]         off;
  logic               active, access, is_half, is_word, mis, we;
  logic [NB-1:0]      word, lane, ext, wdata, dbg;
  logic [3:0]         be;
  assign idx = bus.i_alu_result[NB_ADDR+1:2];
  assign off = bus.i_alu_result[1:0];
  always_comb begin
    state_n = (state == CLEAR && &ptr) ? RUN : state;
    active  = state == RUN && !i_reset;
    access  = bus.i_mem_read || bus.i_mem_write;
    is_half = bus.i_word_size == SZ_HALF;
    is_word = bus.i_word_size != SZ_BYTE && !is_half;
    mis     = active && access && (is_half ? off[0] : (is_word && off != 2'b00));
    word    = mem[idx];
    lane    = is_word ? word : is_half ? word >> {off[1], 4'b0000} : word >> {off, 3'b000};
    ext     = is_word ? lane
            : is_half ? {{(NB-16){bus.i_signed & lane[15]}}, lane[15:0]}
            : {{(NB-8){bus.i_signed & lane[7]}}, lane[7:0]};
    // Replicate narrow store data so every byte-enabled lane sees the right bits
    wdata   = is_word ? bus.i_data_b_to_write
            : is_half ? {(NB/16){bus.i_data_b_to_write[15:0]}}
            : {(NB/8){bus.i_data_b_to_write[7:0]}};
    be      = is_word ? 4'b1111 : is_half ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
    we      = active && bus.i_step && bus.i_mem_write && !mis;
  end
  assign bus.o_misaligned = mis;
  assign bus.o_read_data  = (active && bus.i_mem_read && !mis) ? ext : '0;
  assign bus.o_pc_src     = active && bus.i_branch && bus.i_cero;
  assign bus.o_ready      = state == RUN;
  assign bus.o_debug_data = dbg;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= CLEAR;
      ptr   <= '0;
      dbg   <= '0;
    end else begin
      state <= state_n;
      dbg   <= state == RUN ? mem[bus.i_debug_addr] : '0;
      if (state == CLEAR) ptr <= ptr + 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset && state == CLEAR) mem[ptr] <= '0;
    else if (we) for (int k = 0; k < 4; k++) if (be[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vectors with a queued scoreboard checked by a negedge monitor
module tb_mem_access_stage;
  localparam int F_RD = 0, F_MIS = 1, F_PC = 2, F_RDY = 3, F_DBG = 4;
  typedef struct {
    string       name;
    int          field;
    logic [31:0] val;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  exp_t q[$];
  exp_t e;
  logic [31:0] act;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mem_access_if #(.NB(32), .NB_SIZE_TYPE(3), .NB_ADDR(4)) bus ();
  mem_access_stage #(.NB(32), .NB_SIZE_TYPE(3), .NB_ADDR(4)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );
  function automatic logic [31:0] observe(int f);
    case (f)
      F_RD:    return bus.o_read_data;
      F_MIS:   return {31'b0, bus.o_misaligned};
      F_PC:    return {31'b0, bus.o_pc_src};
      F_RDY:   return {31'b0, bus.o_ready};
      default: return bus.o_debug_data;
    endcase
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      act = observe(e.field);
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end
  task automatic expect_(string n, int f, logic [31:0] v);
    q.push_back('{n, f, v});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set(logic rd, logic wr, logic sg, logic [2:0] sz, logic [31:0] a, logic [31:0] d, logic st);
    bus.i_mem_read = rd;
    bus.i_mem_write = wr;
    bus.i_signed = sg;
    bus.i_word_size = sz;
    bus.i_alu_result = a;
    bus.i_data_b_to_write = d;
    bus.i_step = st;
  endtask
  task automatic idle();
    set(0, 0, 0, 3'd2, 32'h0, 32'h0, 0);
  endtask
  task automatic store(logic [2:0] sz, logic [31:0] a, logic [31:0] d, logic st);
    set(0, 1, 0, sz, a, d, st);
    tick();
    idle();
  endtask
  task automatic load(string n, logic sg, logic [2:0] sz, logic [31:0] a, logic [31:0] v);
    set(1, 0, sg, sz, a, 32'h0, 0);
    expect_(n, F_RD, v);
    expect_({n, "_mis"}, F_MIS, 0);
    tick();
    idle();
  endtask
  task automatic clear_wait(string n);
    for (int i = 1; i <= 16; i++) begin
      tick();
      expect_(n, F_RDY, 32'(i == 16));
    end
  endtask
  initial begin
    idle();
    bus.i_branch = 0;
    bus.i_cero = 0;
    bus.i_debug_addr = '0;
    tick();
    tick();
    rst = 0;
    expect_("rdy_after_reset", F_RDY, 0);
    expect_("pc_in_clear", F_PC, 0);
    clear_wait("clear_ready");
    for (int w = 0; w < 16; w++) begin
      bus.i_debug_addr = 4'(w);
      tick();
      expect_("dbg_cleared", F_DBG, 0);
    end
    store(3'd2, 32'h8, 32'h11223344, 1);
    load("lb_9", 1, 3'd0, 32'h9, 32'h00000033);
    load("lb_b", 1, 3'd0, 32'hB, 32'h00000011);
    load("lhu_a", 0, 3'd1, 32'hA, 32'h00001122);
    load("lw_8", 0, 3'd2, 32'h8, 32'h11223344);
    store(3'd2, 32'h10, 32'hDEADBEEF, 0);
    load("nostep", 0, 3'd2, 32'h10, 32'h0);
    store(3'd2, 32'h10, 32'hDEADBEEF, 1);
    load("step", 0, 3'd2, 32'h10, 32'hDEADBEEF);
    load("alias", 0, 3'd2, 32'h50, 32'hDEADBEEF);
    bus.i_debug_addr = 4'd4;
    tick();
    expect_("dbg_4", F_DBG, 32'hDEADBEEF);
    store(3'd2, 32'h4, 32'h1122AB44, 1);
    load("lb_5", 1, 3'd0, 32'h5, 32'hFFFFFFAB);
    load("lbu_5", 0, 3'd0, 32'h5, 32'h000000AB);
    load("lh_4", 1, 3'd1, 32'h4, 32'hFFFFAB44);
    store(3'd0, 32'h6, 32'h123456CD, 1);
    load("sb_6", 0, 3'd2, 32'h4, 32'h11CDAB44);
    load("lh_6", 1, 3'd1, 32'h6, 32'h000011CD);
    load("lw_sz7", 0, 3'd7, 32'h4, 32'h11CDAB44);
    set(0, 1, 0, 3'd1, 32'h3, 32'h0000BEEF, 1);
    expect_("sh_3_mis", F_MIS, 1);
    tick();
    idle();
    load("sh_3_unchanged", 0, 3'd2, 32'h0, 32'h0);
    set(1, 0, 0, 3'd1, 32'h3, 32'h0, 0);
    expect_("lh_3_data", F_RD, 0);
    expect_("lh_3_mis", F_MIS, 1);
    tick();
    set(1, 0, 0, 3'd2, 32'h2, 32'h0, 0);
    expect_("lw_2_mis", F_MIS, 1);
    tick();
    set(0, 0, 0, 3'd2, 32'h2, 32'h0, 0);
    expect_("noaccess_mis", F_MIS, 0);
    tick();
    load("lb_3_ok", 0, 3'd0, 32'h3, 32'h0);
    set(1, 1, 0, 3'd2, 32'hC, 32'hA5A50F0F, 1);
    expect_("rw_old", F_RD, 0);
    tick();
    idle();
    load("rw_new", 0, 3'd2, 32'hC, 32'hA5A50F0F);
    set(0, 0, 0, 3'd2, 32'h8, 32'h0, 0);
    expect_("noread_data", F_RD, 0);
    tick();
    bus.i_branch = 1;
    bus.i_cero = 0;
    expect_("pc_cero0", F_PC, 0);
    tick();
    bus.i_cero = 1;
    expect_("pc_taken", F_PC, 1);
    tick();
    set(1, 0, 0, 3'd2, 32'h8, 32'h0, 0);
    rst = 1;
    expect_("pc_in_reset", F_PC, 0);
    expect_("rd_in_reset", F_RD, 0);
    tick();
    idle();
    rst = 0;
    expect_("rdy_reset_run", F_RDY, 0);
    for (int i = 0; i < 7; i++) tick();
    expect_("rdy_ptr7", F_RDY, 0);
    rst = 1;
    tick();
    rst = 0;
    expect_("rdy_restart", F_RDY, 0);
    clear_wait("restart_ready");
    bus.i_debug_addr = 4'd4;
    tick();
    expect_("dbg_4_recleared", F_DBG, 0);
    expect_("pc_after_clear", F_PC, 1);
    tick();
    tick();
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
